// File: rtl/logic_op_arbiter_pkg.sv
// Shared types and constants for the two-requester AND/OR arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package logic_op_arbiter_pkg;

   // Default operand/result width
   localparam int DEF_DATA_W = 8;

   // Operation encoding carried on rN_op
   localparam logic OP_AND = 1'b0;
   localparam logic OP_OR  = 1'b1;

   // Arbiter control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/logic_op_unit.sv
// Bitwise AND/OR datapath shared by both requesters.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
module logic_op_unit
   import logic_op_arbiter_pkg::*;
#(
   parameter int W = DEF_DATA_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         op,
   output logic [W-1:0] y
);

   // Select AND or OR of the two operands
   always_comb begin
      y = (op == OP_AND) ? (a & b) : (a | b);
   end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter for two requesters feeding one AND/OR unit.
// Latency: grant in cycle N, rsp_valid in cycle N+2; one op per 3 cycles max.
// Backpressure: result held in RESP until rsp_ready; requests wait until IDLE.
module logic_op_arbiter
   import logic_op_arbiter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [DATA_W-1:0] r0_a,
   input  logic [DATA_W-1:0] r0_b,
   input  logic              r0_op,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [DATA_W-1:0] r1_a,
   input  logic [DATA_W-1:0] r1_b,
   input  logic              r1_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_id,
   output logic              busy,
   output logic [7:0]        done_cnt
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              op_q, op_d;
   logic              id_q, id_d;
   // last_q = 1 means requester 1 was served last, so requester 0 wins a tie
   logic              last_q, last_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_id_q, rsp_id_d;
   logic [7:0]        done_q, done_d;
   logic              gnt0, gnt1, pick1;
   logic [DATA_W-1:0] unit_y;

   // Single shared datapath works on the captured operands
   logic_op_unit #(.W(DATA_W)) u_op (
      .a  (a_q),
      .b  (b_q),
      .op (op_q),
      .y  (unit_y)
   );

   // Next-state, grant and capture logic
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      id_d       = id_q;
      last_d     = last_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      done_d     = done_q;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      pick1      = 1'b0;
      case (state_q)
         IDLE: begin
            // Ready is suppressed during reset so an aborted cycle never handshakes
            if (!rst && (r0_valid || r1_valid)) begin
               if (r0_valid && r1_valid) begin
                  pick1 = ~last_q;
               end else begin
                  pick1 = r1_valid;
               end
               gnt0    = ~pick1;
               gnt1    = pick1;
               a_d     = pick1 ? r1_a  : r0_a;
               b_d     = pick1 ? r1_b  : r0_b;
               op_d    = pick1 ? r1_op : r0_op;
               id_d    = pick1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_data_d = unit_y;
            rsp_id_d   = id_q;
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               last_d  = rsp_id_q;
               done_d  = done_q + 8'd1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= 1'b0;
         id_q       <= 1'b0;
         last_q     <= 1'b1;
         rsp_data_q <= '0;
         rsp_id_q   <= 1'b0;
         done_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         id_q       <= id_d;
         last_q     <= last_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         done_q     <= done_d;
      end
   end

   assign r0_ready  = gnt0;
   assign r1_ready  = gnt1;
   assign rsp_valid = (state_q == RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != IDLE);
   assign done_cnt  = done_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: directed scenarios then random traffic.
// Reference model works at transaction level: grant cycle, response due cycle, counts.
// Outputs sampled 1 time unit after inputs are driven, well away from the clock edge.
module tb_logic_op_arbiter;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         r0_valid, r1_valid;
   logic         r0_ready, r1_ready;
   logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
   logic         r0_op, r1_op;
   logic         rsp_valid, rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_id;
   logic         busy;
   logic [7:0]   done_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   bit         m_idle;
   int         m_cyc;
   int         m_rsp_at;
   logic [7:0] m_data;
   bit         m_id;
   bit         m_last;   // 1: requester 1 served last, requester 0 has priority
   int         m_done;

   logic_op_arbiter #(.DATA_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .r0_valid  (r0_valid),
      .r0_ready  (r0_ready),
      .r0_a      (r0_a),
      .r0_b      (r0_b),
      .r0_op     (r0_op),
      .r1_valid  (r1_valid),
      .r1_ready  (r1_ready),
      .r1_a      (r1_a),
      .r1_b      (r1_b),
      .r1_op     (r1_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy),
      .done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_idle = 1'b1;
      m_last = 1'b1;
      m_done = 0;
   endtask

   function automatic logic [7:0] calc(input logic [7:0] a, input logic [7:0] b, input bit op);
      return op ? (a | b) : (a & b);
   endfunction

   // One clock cycle: drive inputs, check outputs against the model, advance.
   task automatic step(input bit rs,
                       input bit v0, input logic [7:0] a0, input logic [7:0] b0, input bit o0,
                       input bit v1, input logic [7:0] a1, input logic [7:0] b1, input bit o1,
                       input bit rr);
      bit e_r0, e_r1, e_rv;
      rst = rs;
      r0_valid = v0; r0_a = a0; r0_b = b0; r0_op = o0;
      r1_valid = v1; r1_a = a1; r1_b = b1; r1_op = o1;
      rsp_ready = rr;
      #1;
      e_r0 = m_idle && !rs && v0 && (!v1 || m_last);
      e_r1 = m_idle && !rs && v1 && (!v0 || !m_last);
      e_rv = !m_idle && (m_cyc >= m_rsp_at);
      chk("r0_ready", r0_ready, e_r0);
      chk("r1_ready", r1_ready, e_r1);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("busy", busy, !m_idle);
      chk("done_cnt", done_cnt, m_done % 256);
      if (e_rv) begin
         chk("rsp_data", rsp_data, m_data);
         chk("rsp_id", rsp_id, m_id);
      end
      if (rs) begin
         model_reset();
      end else if (e_r0 || e_r1) begin
         m_idle   = 1'b0;
         m_rsp_at = m_cyc + 2;
         m_id     = e_r1;
         m_data   = e_r1 ? calc(a1, b1, o1) : calc(a0, b0, o0);
      end else if (e_rv && rr) begin
         m_idle = 1'b1;
         m_last = m_id;
         m_done++;
      end
      m_cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step(input bit rr);
      step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, rr);
   endtask

   task automatic reset_step();
      step(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1);
   endtask

   initial begin
      m_cyc = 0;
      m_rsp_at = 0;
      m_data = 8'h00;
      m_id = 1'b0;
      rst = 1'b1;
      r0_valid = 1'b1; r0_a = 8'h00; r0_b = 8'h00; r0_op = 1'b0;
      r1_valid = 1'b1; r1_a = 8'h00; r1_b = 8'h00; r1_op = 1'b0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      // Reset values, with both requesters offering while reset is held
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_r0_ready", r0_ready, 1'b0);
      chk("rst_r1_ready", r1_ready, 1'b0);
      chk("rst_rsp_data", rsp_data, 8'h00);
      chk("rst_rsp_id", rsp_id, 1'b0);
      chk("rst_done_cnt", done_cnt, 8'd0);

      // Single r0 AND operation
      step(0, 1, 8'hF0, 8'h3C, 0, 0, 8'h00, 8'h00, 0, 1);
      idle_step(1);
      chk("and_rsp_valid", rsp_valid, 1'b1);
      chk("and_rsp_data", rsp_data, 8'h30);
      chk("and_rsp_id", rsp_id, 1'b0);
      idle_step(1);
      chk("and_done_cnt", done_cnt, 8'd1);

      // Both requesters hold valid: grants alternate starting with r0
      reset_step();
      step(0, 1, 8'hF0, 8'h3C, 1, 1, 8'hAA, 8'h0F, 0, 1);
      step(0, 1, 8'hF0, 8'h3C, 1, 1, 8'hAA, 8'h0F, 0, 1);
      chk("rr_first_data", rsp_data, 8'hFC);
      chk("rr_first_id", rsp_id, 1'b0);
      for (int i = 0; i < 3; i++) step(0, 1, 8'hF0, 8'h3C, 1, 1, 8'hAA, 8'h0F, 0, 1);
      chk("rr_second_data", rsp_data, 8'h0A);
      chk("rr_second_id", rsp_id, 1'b1);
      for (int i = 0; i < 7; i++) step(0, 1, 8'hF0, 8'h3C, 1, 1, 8'hAA, 8'h0F, 0, 1);

      // Consumer stalls 5 cycles in RESP while r1 keeps asking
      reset_step();
      step(0, 1, 8'h5A, 8'hC3, 1, 0, 8'h00, 8'h00, 0, 0);
      step(0, 0, 8'h00, 8'h00, 0, 1, 8'h12, 8'h34, 1, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 8'h00, 0, 1, 8'h12, 8'h34, 1, 0);
      chk("stall_data", rsp_data, 8'hDB);
      chk("stall_busy", busy, 1'b1);
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 8'h00, 0, 1, 8'h12, 8'h34, 1, 1);

      // Reset during EXEC aborts and restores r0 priority
      reset_step();
      for (int i = 0; i < 3; i++) step(0, 1, 8'h0F, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 1);
      step(0, 0, 8'h00, 8'h00, 0, 1, 8'h77, 8'h88, 1, 1);
      step(1, 0, 8'h00, 8'h00, 0, 1, 8'h77, 8'h88, 1, 1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_rsp_valid", rsp_valid, 1'b0);
      for (int i = 0; i < 3; i++) step(0, 1, 8'h11, 8'h22, 1, 1, 8'h77, 8'h88, 1, 1);
      chk("abort_winner_id", rsp_id, 1'b0);

      // done_cnt wraps after 256 operations
      reset_step();
      for (int i = 0; i < 256; i++) begin
         step(0, 1, i[7:0], 8'hFF, 0, 0, 8'h00, 8'h00, 0, 1);
         idle_step(1);
         idle_step(1);
         if (i == 254) chk("wrap_255", done_cnt, 8'd255);
      end
      chk("wrap_0", done_cnt, 8'd0);

      // r1 pulses valid only while RESP is stalled
      step(0, 1, 8'h3C, 8'hC3, 1, 0, 8'h00, 8'h00, 0, 0);
      idle_step(0);
      step(0, 0, 8'h00, 8'h00, 0, 1, 8'h99, 8'h66, 1, 0);
      idle_step(0);
      idle_step(1);
      for (int i = 0; i < 4; i++) idle_step(1);
      chk("pulse_busy", busy, 1'b0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0),
              $urandom_range(0, 1), 8'($urandom), 8'($urandom), $urandom_range(0, 1),
              $urandom_range(0, 1), 8'($urandom), 8'($urandom), $urandom_range(0, 1),
              ($urandom_range(0, 3) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
